// File: rtl/mem_arbiter.sv
// mem_arbiter
// Three-way arbiter in front of a single-port RAM with two-cycle read latency.
// Requesters: instruction fetch (f_*), data load/store (d_*) and io reads (i_*).
// One transaction is in flight at a time: IDLE picks a winner and registers the
// RAM address/data, ACCESS pulses the grant (and the write for a store), and
// reads continue through RD1/RD2, where the winner's rvalid pulses.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   f_req, f_addr              fetch read request; f_gnt, f_rvalid pulses
//   d_req, d_we, d_addr,       data request (d_we=1 store); d_gnt, d_rvalid pulses
//   d_wdata
//   i_req, i_addr              io read request; i_gnt, i_rvalid pulses
//   rdata                      shared read data (straight from mem_rdata)
//   mem_addr, mem_wdata,       registered RAM address, write data, write enable
//   mem_wren
//   mem_rdata                  RAM read data, valid two cycles after the address
//   busy                       high whenever a transaction is in flight
module mem_arbiter #(
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int IO_MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int IOW = (IO_MAX_WAIT < 1) ? 1 : $clog2(IO_MAX_WAIT + 1);
    localparam logic [IOW-1:0] IO_MAX = IOW'(IO_MAX_WAIT);

    typedef enum logic [1:0] {IDLE, ACCESS, RD1, RD2} state_t;
    typedef enum logic [1:0] {W_NONE, W_FETCH, W_DATA, W_IO} winner_t;

    state_t         state, state_next;
    winner_t        winner, pick;
    logic [IOW-1:0] io_wait;

    // Arbitration: data > fetch > io, except that an io requester that has
    // lost IO_MAX_WAIT decisions in a row is forced through.
    always_comb begin
        pick = W_NONE;
        if (i_req && (io_wait == IO_MAX)) begin
            pick = W_IO;
        end else if (d_req) begin
            pick = W_DATA;
        end else if (f_req) begin
            pick = W_FETCH;
        end else if (i_req) begin
            pick = W_IO;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and decoded strobes. mem_wren is only ever set for a store,
    // so it doubles as the store/read flag when leaving ACCESS.
    always_comb begin
        state_next = state;
        f_gnt      = 1'b0;
        d_gnt      = 1'b0;
        i_gnt      = 1'b0;
        f_rvalid   = 1'b0;
        d_rvalid   = 1'b0;
        i_rvalid   = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick != W_NONE) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                f_gnt      = (winner == W_FETCH);
                d_gnt      = (winner == W_DATA);
                i_gnt      = (winner == W_IO);
                state_next = mem_wren ? IDLE : RD1;
            end
            RD1: begin
                state_next = RD2;
            end
            RD2: begin
                f_rvalid   = (winner == W_FETCH);
                d_rvalid   = (winner == W_DATA);
                i_rvalid   = (winner == W_IO);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Transaction capture at the IDLE decision. Everything the RAM sees is
    // latched here, so requesters may change their inputs afterwards without
    // disturbing the transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            winner    <= W_NONE;
            io_wait   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wren  <= 1'b0;
        end else if ((state == IDLE) && (pick != W_NONE)) begin
            winner <= pick;
            case (pick)
                W_DATA:  mem_addr <= d_addr;
                W_FETCH: mem_addr <= f_addr;
                default: mem_addr <= i_addr;
            endcase
            mem_wdata <= (pick == W_DATA) ? d_wdata : '0;
            mem_wren  <= (pick == W_DATA) && d_we;
            if (pick == W_IO) begin
                io_wait <= '0;
            end else if (i_req && (io_wait != IO_MAX)) begin
                io_wait <= io_wait + IOW'(1);
            end
        end else if (state == ACCESS) begin
            mem_wren <= 1'b0;
        end
    end

    assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter: a table of single-transaction vectors with
// hand-computed grants, addresses and read data, followed by hand-written
// sequences for simultaneous requests, io starvation and reset mid-read.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        f_req, d_req, d_we, i_req;
    logic [15:0] f_addr, d_addr, d_wdata, i_addr, mem_rdata;
    logic        f_gnt, f_rvalid, d_gnt, d_rvalid, i_gnt, i_rvalid;
    logic [15:0] rdata, mem_addr, mem_wdata;
    logic        mem_wren, busy;

    int testsRun = 0;
    int failCount = 0;

    typedef struct {
        logic        f_req;
        logic        d_req;
        logic        d_we;
        logic        i_req;
        logic [15:0] f_addr;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic [15:0] i_addr;
        logic [15:0] rd_in;
        logic [2:0]  exp_gnt;
        logic        exp_wren;
        logic [15:0] exp_addr;
        logic        exp_read;
    } vec_t;

    vec_t vecs[8];

    mem_arbiter #(.AW(16), .DW(16), .IO_MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wren(mem_wren), .mem_rdata(mem_rdata), .busy(busy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge, where both driving
    // and sampling happen.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic dropRequests();
        f_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        i_req = 1'b0;
    endtask

    // One vector: present the requests in IDLE, check the ACCESS cycle, then
    // the RD1/RD2 cycles for reads, and the return to IDLE.
    task automatic applyStimulus(input vec_t v, input int idx);
        f_req = v.f_req;   f_addr = v.f_addr;
        d_req = v.d_req;   d_we = v.d_we;  d_addr = v.d_addr;  d_wdata = v.d_wdata;
        i_req = v.i_req;   i_addr = v.i_addr;
        mem_rdata = v.rd_in;
        checkOutput($sformatf("v%0d idle_gnt", idx), 32'({f_gnt, d_gnt, i_gnt}), 32'd0);
        step();
        checkOutput($sformatf("v%0d gnt", idx), 32'({f_gnt, d_gnt, i_gnt}), 32'(v.exp_gnt));
        checkOutput($sformatf("v%0d wren", idx), 32'(mem_wren), 32'(v.exp_wren));
        checkOutput($sformatf("v%0d addr", idx), 32'(mem_addr), 32'(v.exp_addr));
        checkOutput($sformatf("v%0d busy_acc", idx), 32'(busy), 32'd1);
        if (v.exp_wren) begin
            checkOutput($sformatf("v%0d wdata", idx), 32'(mem_wdata), 32'(v.d_wdata));
        end
        dropRequests();
        if (v.exp_read) begin
            step();
            checkOutput($sformatf("v%0d rd1_rvalid", idx), 32'({f_rvalid, d_rvalid, i_rvalid}), 32'd0);
            checkOutput($sformatf("v%0d rd1_busy", idx), 32'(busy), 32'd1);
            checkOutput($sformatf("v%0d rd1_wren", idx), 32'(mem_wren), 32'd0);
            step();
            checkOutput($sformatf("v%0d rvalid", idx), 32'({f_rvalid, d_rvalid, i_rvalid}), 32'(v.exp_gnt));
            checkOutput($sformatf("v%0d rdata", idx), 32'(rdata), 32'(v.rd_in));
            checkOutput($sformatf("v%0d rd2_busy", idx), 32'(busy), 32'd1);
        end
        step();
        checkOutput($sformatf("v%0d idle_busy", idx), 32'(busy), 32'd0);
        checkOutput($sformatf("v%0d idle_rvalid", idx), 32'({f_rvalid, d_rvalid, i_rvalid}), 32'd0);
        checkOutput($sformatf("v%0d idle_wren", idx), 32'(mem_wren), 32'd0);
    endtask

    initial begin
        // Fields: f_req d_req d_we i_req  f_addr d_addr d_wdata i_addr rd_in
        //         exp_gnt{f,d,i} exp_wren exp_addr exp_read
        vecs[0] = '{1, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'hABCD, 3'b100, 0, 16'h0010, 1};
        vecs[1] = '{0, 1, 1, 0, 16'h0000, 16'h0200, 16'h1234, 16'h0000, 16'h0000, 3'b010, 1, 16'h0200, 0};
        vecs[2] = '{0, 1, 0, 0, 16'h0000, 16'h0300, 16'h0000, 16'h0000, 16'h5555, 3'b010, 0, 16'h0300, 1};
        vecs[3] = '{0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0400, 16'h0F0F, 3'b001, 0, 16'h0400, 1};
        vecs[4] = '{1, 1, 0, 0, 16'h0011, 16'h0310, 16'h0000, 16'h0000, 16'h1111, 3'b010, 0, 16'h0310, 1};
        vecs[5] = '{1, 0, 0, 1, 16'h0020, 16'h0000, 16'h0000, 16'h0420, 16'h2222, 3'b100, 0, 16'h0020, 1};
        vecs[6] = '{0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0430, 16'h3333, 3'b001, 0, 16'h0430, 1};
        vecs[7] = '{0, 1, 1, 0, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 3'b010, 1, 16'hFFFF, 0};

        reset = 1'b0;
        dropRequests();
        f_addr = '0; d_addr = '0; d_wdata = '0; i_addr = '0; mem_rdata = '0;
        step();
        step();
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset gnt", 32'({f_gnt, d_gnt, i_gnt}), 32'd0);
        checkOutput("reset rvalid", 32'({f_rvalid, d_rvalid, i_rvalid}), 32'd0);
        checkOutput("reset mem", 32'({mem_wren, mem_addr, mem_wdata}), 32'd0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Data and fetch arrive together: data first, fetch at the next IDLE.
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0204; d_wdata = 16'hBEEF;
        f_req = 1'b1; f_addr = 16'h0030; mem_rdata = 16'h4444;
        step();
        checkOutput("both d_gnt", 32'({f_gnt, d_gnt, i_gnt}), 32'b010);
        checkOutput("both wdata", 32'(mem_wdata), 32'hBEEF);
        d_req = 1'b0; d_we = 1'b0;
        step();
        checkOutput("both idle", 32'({busy, f_gnt}), 32'd0);
        step();
        checkOutput("both f_gnt", 32'({f_gnt, d_gnt, i_gnt}), 32'b100);
        checkOutput("both f_addr", 32'(mem_addr), 32'h0030);
        f_req = 1'b0;
        step();
        step();
        checkOutput("both f_rvalid", 32'({f_rvalid, d_rvalid, i_rvalid}), 32'b100);
        checkOutput("both rdata", 32'(rdata), 32'h4444);
        step();

        // io starvation: four lost decisions, then io is forced through.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        step();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0250; d_wdata = 16'h0042;
        i_req = 1'b1; i_addr = 16'h0440; mem_rdata = 16'h6666;
        for (int k = 0; k < 4; k++) begin
            step();
            checkOutput($sformatf("starve%0d gnt", k), 32'({f_gnt, d_gnt, i_gnt}), 32'b010);
            step();
        end
        checkOutput("starve io_wait", 32'(dut.io_wait), 32'd4);
        step();
        checkOutput("starve i_gnt", 32'({f_gnt, d_gnt, i_gnt}), 32'b001);
        checkOutput("starve i_addr", 32'(mem_addr), 32'h0440);
        checkOutput("starve wren", 32'(mem_wren), 32'd0);
        checkOutput("starve io_wait_clr", 32'(dut.io_wait), 32'd0);
        dropRequests();
        step();
        step();
        checkOutput("starve i_rvalid", 32'({f_rvalid, d_rvalid, i_rvalid}), 32'b001);
        checkOutput("starve rdata", 32'(rdata), 32'h6666);
        step();

        // Reset asserted in RD1 of a load aborts it.
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0500; mem_rdata = 16'h7777;
        step();
        checkOutput("abort d_gnt", 32'(d_gnt), 32'd1);
        dropRequests();
        step();
        checkOutput("abort in_rd1", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("abort outs", 32'({f_gnt, d_gnt, i_gnt, f_rvalid, d_rvalid, i_rvalid, mem_wren, busy}), 32'd0);
        checkOutput("abort mem", 32'({mem_addr, mem_wdata}), 32'd0);
        step();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checkOutput($sformatf("abort post%0d", k), 32'({d_rvalid, busy, mem_wren}), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
